servo_pulse_decoder: RTL and testbench
======================================

// Module: servo_pulse_decoder
// PURPOSE
//  Receive-side counterpart of the servo tester PWM generator. Measures the high time of an
//  incoming RC-servo pulse, converts it to an 8-bit position (same LSB step as the generator),
//  and flags runt, overlong and missing frames. Sits between an input pin and the 7-seg/status logic.
// PARAMETERS
//  MIN_PULSE  10000   high cycles that map to position 0 (1.0 ms @ 10 MHz)
//  STEP       40      high cycles per position LSB (the generator's MAX_SIG)
//  RUNT       5000    pulses with W < RUNT are errors (W defined in BEHAVIOUR)
//  MAX_PULSE  25000   pulses with W > MAX_PULSE are errors (2.5 ms)
//  TIMEOUT    250000  cycles without a rising edge before valid drops (25 ms)
// PORTS
//  clk         in   1  clock
//  reset       in   1  synchronous, active-high reset
//  pwm_in      in   1  asynchronous servo pulse input
//  position    out  8  last decoded position
//  sample_stb  out  1  one-cycle strobe: position updated
//  valid       out  1  a good pulse was decoded within the last TIMEOUT cycles
//  error       out  1  one-cycle strobe: runt or overlong pulse
//  pwm_sync    out  1  synchronised pwm_in, for display/debug
// BEHAVIOUR
//  - Reset: position=0, sample_stb=0, valid=0, error=0, pwm_sync=0, all counters 0, state WAIT_LOW.
//  - pwm_in passes through a 2-flop synchroniser; pwm_sync is its output. Edges are detected on
//    pwm_sync against a one-cycle-delayed copy.
//  - W = number of cycles pwm_sync is high: first cycle counts as 1, falling-edge cycle excluded.
//  - Counters are 21 bits wide. The width counter saturates rather than wrapping.
//  - States:
//    - WAIT_LOW: entered at reset. Waits for pwm_sync=0, then goes to LOW, so a partial pulse
//      is never measured.
//    - LOW: on a rising edge, go to HIGH. The width counter and step prescaler restart at 0 and the
//      accumulator is cleared.
//    - HIGH: the width counter increments each cycle. Once W > MIN_PULSE, the prescaler counts;
//      every STEP cycles the accumulator increments, saturating at 255. This implements
//      pos = min(255, max(0, floor((W - MIN_PULSE) / STEP))).
//    - HIGH, falling edge: if RUNT <= W <= MAX_PULSE, then position <= pos, sample_stb=1 and
//      valid=1 on the next cycle. Otherwise error=1 and position is held. Go to LOW.
//    - HIGH, overlong: when W passes MAX_PULSE while still high, error=1 once and go to STUCK.
//    - STUCK: waits for pwm_sync=0, then goes to LOW. No position update.
//  - Latency: position and sample_stb are updated 4 clk after the falling edge of pwm_in.
//  - Frame timeout:
//    - The frame counter clears on every rising edge of pwm_sync and saturates.
//    - Reaching TIMEOUT sets valid <= 0. position is held.
//    - Timeout is independent of state, so a stuck-high input also times out.
//  - sample_stb and error are never high in the same cycle. valid is set only by a good pulse.
//  - Reset asserted mid-pulse aborts the measurement. The next pulse is measured only after a
//    low is seen (WAIT_LOW).
// CONFIGURATION
//  SERVO_DEC_GLITCH_FILTER_EN
//  - Defined: a 3-sample majority filter is inserted after the synchroniser and drives pwm_sync.
//    Single-cycle glitches are rejected. Add 2 cycles to all latencies (4 -> 6 clk). W is unchanged
//    for clean pulses.
//  - Undefined: no filter; pwm_sync is the raw synchroniser output.
// TESTING
//  - reset, then pwm_in high 15000 cycles per 200000-cycle frame -> sample_stb 4 clk after each
//    falling edge, position=125, valid=1.
//  - high 9000 cycles -> position=0, no error. High 22000 -> position=255 (saturated), no error.
//  - high 3000 cycles -> error strobe once, position keeps its prior value, no sample_stb.
//  - held high 40000 cycles -> single error at W=25001, then STUCK; after release, the next
//    15000-cycle pulse decodes to 125.
//  - pwm_in held low 260000 cycles after a good pulse -> valid falls 250000 cycles after the last
//    rising edge, position held.
//  - reset asserted mid-pulse, released while pwm_in still high -> that pulse is ignored; next pulse
//    decodes. With SERVO_DEC_GLITCH_FILTER_EN: 1-cycle low glitch in a 15000-cycle pulse ->
//    position=125.

Source files
------------

// File: rtl/servo_pulse_decoder.sv
// Servo pulse decoder: measures RC-servo pulse high time and maps it to an 8-bit position.
// Optional SERVO_DEC_GLITCH_FILTER_EN adds a 3-sample majority filter ahead of pwm_sync.
module servo_pulse_decoder #(
    parameter int MIN_PULSE = 10000,
    parameter int STEP      = 40,
    parameter int RUNT      = 5000,
    parameter int MAX_PULSE = 25000,
    parameter int TIMEOUT   = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [7:0] position,
    output logic       sample_stb,
    output logic       valid,
    output logic       error,
    output logic       pwm_sync
);

    localparam int CW = 21;
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_PULSE);
    localparam logic [CW-1:0] RUNT_C   = CW'(RUNT);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_PULSE);
    localparam logic [CW-1:0] TO_C     = CW'(TIMEOUT);
    localparam logic [CW-1:0] STEP_M1  = CW'(STEP - 1);
    // Low cycles needed in WAIT_LOW; longer than the input pipeline so that
    // the zeros left in the flops by reset are never taken as a real low.
    localparam logic [CW-1:0] SETTLE   = CW'(8);

    typedef enum logic [1:0] {WAIT_LOW, LOW, HIGH, STUCK} state_t;

    logic sync1, sync2;
    logic lvl, lvl_d, rise;

    state_t        state, state_n;
    logic [CW-1:0] width, width_n, width_inc;
    logic [CW-1:0] presc, presc_n;
    logic [CW-1:0] frame, frame_n;
    logic [7:0]    acc, acc_n, pos_n;
    logic          stb_n, err_n, valid_n;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef SERVO_DEC_GLITCH_FILTER_EN
    logic f1, f2, filt;

    // Majority of three consecutive samples rejects single-cycle glitches
    always_ff @(posedge clk) begin
        if (reset) begin
            f1   <= 1'b0;
            f2   <= 1'b0;
            filt <= 1'b0;
        end else begin
            f1   <= sync2;
            f2   <= f1;
            filt <= (sync2 & f1) | (sync2 & f2) | (f1 & f2);
        end
    end

    assign pwm_sync = filt;
`else
    assign pwm_sync = sync2;
`endif

    // Registered level and its delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
        end else begin
            lvl   <= pwm_sync;
            lvl_d <= lvl;
        end
    end

    assign rise      = lvl & ~lvl_d;
    assign width_inc = (width == '1) ? width : width + 1'b1;

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_LOW;
            width      <= '0;
            presc      <= '0;
            frame      <= '0;
            acc        <= '0;
            position   <= '0;
            sample_stb <= 1'b0;
            error      <= 1'b0;
            valid      <= 1'b0;
        end else begin
            state      <= state_n;
            width      <= width_n;
            presc      <= presc_n;
            frame      <= frame_n;
            acc        <= acc_n;
            position   <= pos_n;
            sample_stb <= stb_n;
            error      <= err_n;
            valid      <= valid_n;
        end
    end

    // Next-state, measurement and frame-timeout logic
    always_comb begin
        state_n = state;
        width_n = width;
        presc_n = presc;
        acc_n   = acc;
        pos_n   = position;
        stb_n   = 1'b0;
        err_n   = 1'b0;
        valid_n = valid;
        frame_n = frame;

        if (rise) begin
            frame_n = '0;
        end else begin
            if (frame != '1) begin
                frame_n = frame + 1'b1;
            end
            if (frame_n >= TO_C) begin
                valid_n = 1'b0;
            end
        end

        unique case (state)
            WAIT_LOW: begin
                if (lvl) begin
                    width_n = '0;
                end else begin
                    width_n = width_inc;
                    if (width_inc >= SETTLE) begin
                        state_n = LOW;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    // The rising-edge cycle is the first high cycle
                    state_n = HIGH;
                    width_n = CW'(1);
                    presc_n = '0;
                    acc_n   = '0;
                end
            end
            HIGH: begin
                if (!lvl) begin
                    if (width >= RUNT_C && width <= MAX_C) begin
                        pos_n   = acc;
                        stb_n   = 1'b1;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = LOW;
                end else begin
                    width_n = width_inc;
                    if (width_inc > MAX_C) begin
                        err_n   = 1'b1;
                        state_n = STUCK;
                    end else if (width_inc > MIN_C) begin
                        if (presc == STEP_M1) begin
                            presc_n = '0;
                            if (acc != 8'hFF) begin
                                acc_n = acc + 1'b1;
                            end
                        end else begin
                            presc_n = presc + 1'b1;
                        end
                    end
                end
            end
            STUCK: begin
                if (!lvl) begin
                    state_n = LOW;
                end
            end
            default: state_n = WAIT_LOW;
        endcase
    end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Testbench for servo_pulse_decoder with scaled-down timing parameters.
// Scoreboard queue of expected strobes, checked by an independent monitor.
module tb_servo_pulse_decoder;

    localparam int MIN  = 200;
    localparam int STP  = 4;
    localparam int RNT  = 100;
    localparam int MAXP = 1400;
    localparam int TO   = 4000;
`ifdef SERVO_DEC_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        bit is_err;
        int pos;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pwm_in = 1'b0;
    logic [7:0] position;
    logic       sample_stb;
    logic       valid;
    logic       error;
    logic       pwm_sync;

    ev_t q[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  held_pos = 0;

    servo_pulse_decoder #(
        .MIN_PULSE(MIN),
        .STEP(STP),
        .RUNT(RNT),
        .MAX_PULSE(MAXP),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pwm_in(pwm_in),
        .position(position),
        .sample_stb(sample_stb),
        .valid(valid),
        .error(error),
        .pwm_sync(pwm_sync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected position from the pulse width
    function automatic int model_pos(int w);
        int p;
        p = (w - MIN) / STP;
        if (w <= MIN) p = 0;
        if (p > 255) p = 255;
        return p;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_for(int w, int n);
        ev_t e;
        if (w > MAXP) begin
            e = '{1'b1, held_pos, n + MAXP + LAT};
        end else if (w < RNT) begin
            e = '{1'b1, held_pos, n + w + LAT};
        end else begin
            held_pos = model_pos(w);
            e = '{1'b0, held_pos, n + w + LAT};
        end
        q.push_back(e);
    endtask

    // One pulse of w high samples followed by gap low cycles
    task automatic pulse(input int w, input int gap, output int n);
        @(negedge clk);
        n = cyc + 1;
        pwm_in = 1'b1;
        push_for(w, n);
        repeat (w) @(negedge clk);
        pwm_in = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("queue_drained", q.size(), 0);
    endtask

    // Monitor: pops and compares on every strobe
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            if (sample_stb && error) begin
                n_chk++;
                n_fail++;
                $display("FAIL stb_err_same_cycle at cycle %0d", cyc);
            end
            if (sample_stb || error) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event stb=%0b err=%0b pos=%0d at cycle %0d",
                             sample_stb, error, position, cyc);
                end else begin
                    e = q.pop_front();
                    chk("event_is_error", int'(error), int'(e.is_err));
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_position", int'(position), e.pos);
                    if (!e.is_err) chk("valid_after_good", int'(valid), 1);
                end
            end else if (q.size() != 0 && cyc > q[0].cyc) begin
                e = q.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL missing_event err=%0b due cycle %0d, now %0d",
                         e.is_err, e.cyc, cyc);
            end
        end
    end

    initial begin
        int n;
        int w;
        int r;

        repeat (4) @(negedge clk);
        chk("reset_position", int'(position), 0);
        chk("reset_stb", int'(sample_stb), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_error", int'(error), 0);
        chk("reset_pwm_sync", int'(pwm_sync), 0);
        reset = 1'b0;
        repeat (50) @(negedge clk);

        pulse(700, 2300, n);
        pulse(700, 2300, n);
        chk("valid_steady", int'(valid), 1);
        pulse(150, 300, n);
        pulse(1300, 300, n);
        pulse(60, 300, n);
        chk("position_held_runt", int'(position), 255);
        pulse(2000, 300, n);
        pulse(700, 300, n);
        pulse(RNT, 200, n);
        pulse(RNT - 1, 200, n);
        pulse(MAXP, 200, n);
        pulse(MAXP + 1, 200, n);
        pulse(MIN + STP, 200, n);
        pulse(MIN + STP - 1, 200, n);

        pulse(700, 0, n);
        while (cyc < n + LAT + TO - 1) @(negedge clk);
        chk("valid_before_timeout", int'(valid), 1);
        @(negedge clk);
        chk("valid_after_timeout", int'(valid), 0);
        chk("position_after_timeout", int'(position), 125);
        chk("pwm_sync_low", int'(pwm_sync), 0);

        drain(100);
        pwm_in = 1'b1;
        repeat (300) @(negedge clk);
        chk("pwm_sync_high", int'(pwm_sync), 1);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("midreset_position", int'(position), 0);
        chk("midreset_valid", int'(valid), 0);
        held_pos = 0;
        reset = 1'b0;
        repeat (400) @(negedge clk);
        pwm_in = 1'b0;
        repeat (200) @(negedge clk);
        chk("partial_ignored_pos", int'(position), 0);
        pulse(700, 300, n);

`ifdef SERVO_DEC_GLITCH_FILTER_EN
        @(negedge clk);
        n = cyc + 1;
        pwm_in = 1'b1;
        held_pos = 125;
        q.push_back('{1'b0, 125, n + 700 + LAT});
        repeat (350) @(negedge clk);
        pwm_in = 1'b0;
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (349) @(negedge clk);
        pwm_in = 1'b0;
        repeat (300) @(negedge clk);
`endif

        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) w = $urandom_range(10, RNT - 1);
            else if (r == 1) w = $urandom_range(MAXP + 1, MAXP + 300);
            else w = $urandom_range(RNT, MAXP);
            pulse(w, $urandom_range(20, 200), n);
        end

        drain(5000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
